dispensador_cambio: RTL and testbench
=====================================

// Module: dispensador_cambio
// PURPOSE
// - Dispense side of the vending coin path: takes a change amount (same 12-bit unit as the coin adder's monto)
//   and pays it out one coin at a time to the coin-ejector mechanism, greedy, largest denomination first.
// - Sits after the coin adder/price compare; ejector acknowledges each coin via a valid/ack handshake.
// - Reports leftover amount not payable with available denominations, plus coin count for the display.
// PARAMETERS
// - W        12   width of amount datapath (monto, resto)
// - VAL_01   50   value of coin code 2'b01 (smallest)
// - VAL_10   100  value of coin code 2'b10
// - VAL_11   500  value of coin code 2'b11 (largest); required VAL_01 < VAL_10 < VAL_11, all > 0
// PORTS
// - clk          in   1   clock, rising edge
// - rst          in   1   asynchronous reset, active-low
// - start        in   1   1-cycle request; sampled only in IDLE
// - monto        in   W   change to return, captured when start accepted
// - cancel       in   1   abort payout; finishes after current coin handshake is resolved (see below)
// - ack          in   1   ejector has taken the presented coin
// - moneda       out  2   coin code presented (00 = none)
// - moneda_valid out  1   moneda is valid, held until ack
// - busy         out  1   1 in any state except IDLE
// - done         out  1   1-cycle pulse, payout finished
// - resto        out  W   amount not paid out; valid from done, held until next start accepted
// - num_monedas  out  8   coins dispensed in current/last payout; saturates at 255
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, moneda=00, moneda_valid=0, busy=0, done=0, resto=0, num_monedas=0, remaining=0.
// - States: IDLE, SELECT, EMIT, FIN.
// - IDLE: start=1 -> remaining<=monto, num_monedas<=0, resto<=0, go SELECT. start=0 -> stay.
// - SELECT (1 cycle, comb. compare on remaining):
//   cancel=1 -> FIN; else remaining>=VAL_11 -> code 11; else >=VAL_10 -> 10; else >=VAL_01 -> 01;
//   code chosen -> register moneda, go EMIT; no coin fits -> FIN.
// - EMIT: moneda_valid=1, moneda stable. ack=1 -> remaining<=remaining-value(moneda),
//   num_monedas<=num_monedas+1 (sat), moneda<=00, moneda_valid<=0, go SELECT. ack=0 -> hold (no timeout).
//   cancel in EMIT is not acted on until the coin is acked (coin already released cannot be recalled);
//   a cancel pulse seen in EMIT is latched (cancel_pend) and honoured in the following SELECT.
// - FIN: resto<=remaining, done=1 for exactly this cycle, cancel_pend cleared, go IDLE.
// - Latency: start -> first moneda_valid = 2 cycles (IDLE->SELECT->EMIT); ack -> next moneda_valid = 2 cycles;
//   last ack -> done = 2 cycles (SELECT->FIN). monto below VAL_01: start -> done = 2 cycles, zero coins.
// - Arithmetic: unsigned W-bit; subtraction never underflows (only coin with value<=remaining chosen).
// - start while busy: ignored, no side effects. ack outside EMIT: ignored.
// - start and done may coincide with nothing: start is only accepted in IDLE, i.e. the cycle after FIN at earliest.
// - Reset mid-payout: immediate return to reset values; coin currently presented is dropped (valid falls async).
// TESTING
// - monto=650, ack 1 cycle after each valid -> codes 11,10,01 in order, num_monedas=3, done pulse, resto=0.
// - monto=30 -> no moneda_valid, done 2 cycles after start, resto=30, num_monedas=0.
// - monto=1200, ack delayed 4 cycles per coin -> moneda/valid stable while waiting; codes 11,11,10,10; resto=0.
// - monto=575 -> codes 11,01; resto=25; then start again with monto=0 -> done, resto=0, num_monedas=0.
// - monto=1500, cancel pulsed during 2nd EMIT -> 2nd coin completes on ack, no 3rd coin, resto=500, num_monedas=2.
// - start again while busy -> ignored; rst=0 during EMIT -> moneda_valid=0, busy=0 immediately, later ack ignored.

Source files
------------

// File: rtl/dispensador_cambio.sv
// Greedy change dispenser: pays out an amount one coin at a time, largest
// denomination first, handing each coin to the ejector over a valid/ack handshake.
module dispensador_cambio #(
    parameter int W      = 12,
    parameter int VAL_01 = 50,
    parameter int VAL_10 = 100,
    parameter int VAL_11 = 500
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] monto,
    input  logic         cancel,
    input  logic         ack,
    output logic [1:0]   moneda,
    output logic         moneda_valid,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] resto,
    output logic [7:0]   num_monedas
);

    typedef enum logic [1:0] {IDLE, SELECT, EMIT, FIN} state_t;

    localparam logic [W-1:0] V01 = W'(VAL_01);
    localparam logic [W-1:0] V10 = W'(VAL_10);
    localparam logic [W-1:0] V11 = W'(VAL_11);

    state_t       state;
    logic [W-1:0] remaining;
    logic         cancel_pend;
    logic [1:0]   pick;
    logic [W-1:0] coin_val;

    // Largest coin that still fits; 00 means nothing more can be paid.
    always_comb begin
        pick = 2'b00;
        if (remaining >= V11)      pick = 2'b11;
        else if (remaining >= V10) pick = 2'b10;
        else if (remaining >= V01) pick = 2'b01;
    end

    always_comb begin
        case (moneda)
            2'b11:   coin_val = V11;
            2'b10:   coin_val = V10;
            2'b01:   coin_val = V01;
            default: coin_val = '0;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            remaining    <= '0;
            cancel_pend  <= 1'b0;
            moneda       <= 2'b00;
            moneda_valid <= 1'b0;
            done         <= 1'b0;
            resto        <= '0;
            num_monedas  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining   <= monto;
                        num_monedas <= '0;
                        resto       <= '0;
                        cancel_pend <= 1'b0;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    // resto is loaded here so it is already valid alongside done
                    if (cancel || cancel_pend || pick == 2'b00) begin
                        resto <= remaining;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        moneda       <= pick;
                        moneda_valid <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    // A coin in flight cannot be recalled; remember the cancel for later.
                    if (cancel) cancel_pend <= 1'b1;
                    if (ack) begin
                        remaining    <= remaining - coin_val;
                        if (num_monedas != 8'hFF) num_monedas <= num_monedas + 8'd1;
                        moneda       <= 2'b00;
                        moneda_valid <= 1'b0;
                        state        <= SELECT;
                    end
                end
                FIN: begin
                    resto       <= remaining;
                    cancel_pend <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dispensador_cambio.sv
// Directed bench for dispensador_cambio: table of payouts with hand-computed
// coin sequences, plus reset-state and mid-payout reset sequences.
module tb_dispensador_cambio;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] monto;
    logic        cancel;
    logic        ack;
    logic [1:0]  moneda;
    logic        moneda_valid;
    logic        busy;
    logic        done;
    logic [11:0] resto;
    logic [7:0]  num_monedas;

    int checks = 0;
    int errors = 0;

    dispensador_cambio dut (
        .clk(clk), .rst(rst), .start(start), .monto(monto), .cancel(cancel), .ack(ack),
        .moneda(moneda), .moneda_valid(moneda_valid), .busy(busy), .done(done),
        .resto(resto), .num_monedas(num_monedas)
    );

    always #5 clk = ~clk;

    // codes: coin k of the payout sits at bits [2k+1:2k]
    typedef struct {
        logic [11:0] monto;
        int          delay;
        int          cancel_k;
        bit          busy_start;
        logic [19:0] codes;
        int          n;
        logic [11:0] resto;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [19:0] got;
        int ng, t, wait_c, last_ack_t;
        bit tim_ok, stab_ok, done_seen;
        logic [11:0] r;
        logic [7:0]  nm;
        got = '0; ng = 0; wait_c = 0; last_ack_t = 0;
        tim_ok = 1; stab_ok = 1; done_seen = 0; r = '0; nm = '0;
        @(negedge clk); start = 1'b1; monto = v.monto; t = 0;
        @(negedge clk); start = 1'b0; t = 1;
        chk($sformatf("v%0d busy_after_start", idx), int'(busy), 1);
        while (!done_seen && t < 400) begin
            ack = 1'b0; cancel = 1'b0; start = 1'b0;
            if (moneda_valid) begin
                if (wait_c == 0) begin
                    if (ng < 10) got[2*ng +: 2] = moneda;
                    ng++;
                    if (t - last_ack_t != 2) tim_ok = 0;
                    if (v.busy_start && ng == 1) begin start = 1'b1; monto = 12'd30; end
                    if (ng == v.cancel_k) cancel = 1'b1;
                end else if (ng >= 1 && ng <= 10 && moneda != got[2*(ng-1) +: 2]) begin
                    stab_ok = 0;
                end
                if (wait_c == v.delay) begin
                    ack = 1'b1; last_ack_t = t; wait_c = 0;
                end else begin
                    wait_c++;
                end
            end else if (done) begin
                done_seen = 1; r = resto; nm = num_monedas;
                if (t - last_ack_t != 2) tim_ok = 0;
            end
            @(negedge clk); t++;
        end
        ack = 1'b0; cancel = 1'b0; start = 1'b0;
        chk($sformatf("v%0d done_seen", idx), int'(done_seen), 1);
        chk($sformatf("v%0d codes", idx), int'(got), int'(v.codes));
        chk($sformatf("v%0d coin_count", idx), ng, v.n);
        chk($sformatf("v%0d num_monedas", idx), int'(nm), v.n);
        chk($sformatf("v%0d resto", idx), int'(r), int'(v.resto));
        chk($sformatf("v%0d latency", idx), int'(tim_ok), 1);
        chk($sformatf("v%0d coin_stable", idx), int'(stab_ok), 1);
        chk($sformatf("v%0d done_one_cycle", idx), int'(done), 0);
        chk($sformatf("v%0d idle_after", idx), int'(busy), 0);
        chk($sformatf("v%0d resto_held", idx), int'(resto), int'(v.resto));
    endtask

    initial begin
        //                monto  dly cancel busy_st codes       n  resto
        vecs[0] = '{12'd650,  1, 0, 1'b1, 20'h0001B, 3, 12'd0};
        vecs[1] = '{12'd30,   0, 0, 1'b0, 20'h00000, 0, 12'd30};
        vecs[2] = '{12'd1200, 4, 0, 1'b0, 20'h000AF, 4, 12'd0};
        vecs[3] = '{12'd575,  0, 0, 1'b0, 20'h00007, 2, 12'd25};
        vecs[4] = '{12'd0,    0, 0, 1'b0, 20'h00000, 0, 12'd0};
        vecs[5] = '{12'd1500, 2, 2, 1'b0, 20'h0000F, 2, 12'd500};
        vecs[6] = '{12'd499,  1, 0, 1'b0, 20'h001AA, 5, 12'd49};
        vecs[7] = '{12'd4095, 0, 0, 1'b0, 20'h1FFFF, 9, 12'd45};
        vecs[8] = '{12'd50,   3, 0, 1'b0, 20'h00001, 1, 12'd0};

        rst = 1'b0; start = 1'b0; monto = '0; cancel = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(moneda_valid), 0);
        chk("reset_moneda", int'(moneda), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_resto", int'(resto), 0);
        chk("reset_num", int'(num_monedas), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", int'(busy), 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset while a coin is presented: valid and busy must drop without a clock edge.
        @(negedge clk); start = 1'b1; monto = 12'd650;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("rstmid_valid_before", int'(moneda_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_valid", int'(moneda_valid), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_moneda", int'(moneda), 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        @(negedge clk);
        chk("rstmid_ack_ignored_busy", int'(busy), 0);
        chk("rstmid_ack_ignored_num", int'(num_monedas), 0);
        chk("rstmid_ack_ignored_valid", int'(moneda_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
